// File: rtl/trigger_sequencer_pkg.sv
// Shared types and helpers for the multi-stage trigger sequencer.
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2
    } state_t;

    // Software may program a last-stage index beyond the implemented channels.
    function automatic int clamp_stage(input int idx, input int last);
        return (idx > last) ? last : idx;
    endfunction

endpackage

// File: rtl/trigger_sequencer_if.sv
// Sample stream feeding the trigger sequencer.
interface trigger_sequencer_if #(
    parameter int SDW = 32
);
    logic           sti_transfer;
    logic [SDW-1:0] sti_tdata;

    modport master (output sti_transfer, output sti_tdata);
    modport slave  (input  sti_transfer, input  sti_tdata);
endinterface

// File: rtl/trigger_sequencer_match.sv
// Per-channel comparator: per-bit transition/level match, then AND/OR combine.
module trigger_match #(
    parameter int SDW = 32
) (
    input  logic [SDW-1:0] prv,
    input  logic [SDW-1:0] data,
    input  logic [SDW-1:0] cfg_or,
    input  logic [SDW-1:0] cfg_and,
    input  logic [SDW-1:0] cfg_0_0,
    input  logic [SDW-1:0] cfg_0_1,
    input  logic [SDW-1:0] cfg_1_0,
    input  logic [SDW-1:0] cfg_1_1,
    output logic           hit
);
    logic [SDW-1:0] cmp;

    assign cmp = (~prv & ~data & cfg_0_0) | (~prv &  data & cfg_0_1) |
                 ( prv & ~data & cfg_1_0) | ( prv &  data & cfg_1_1);

    // An empty AND mask must not turn into a vacuous always-hit.
    assign hit = ((&(cmp | ~cfg_and)) & (|cfg_and)) | (|(cmp & cfg_or));
endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger: per-channel comparators chained through a stage sequencer
// with occurrence counters and a post-trigger delay; emits a one-cycle event.
module trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int SDW = 32,
    parameter int CHN = 4,
    parameter int CNW = 16,
    parameter int SIW = (CHN > 1) ? $clog2(CHN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CHN*SDW-1:0] cfg_or,
    input  logic [CHN*SDW-1:0] cfg_and,
    input  logic [CHN*SDW-1:0] cfg_0_0,
    input  logic [CHN*SDW-1:0] cfg_0_1,
    input  logic [CHN*SDW-1:0] cfg_1_0,
    input  logic [CHN*SDW-1:0] cfg_1_1,
    input  logic [CHN*CNW-1:0] cfg_cnt,
    input  logic [SIW-1:0]     cfg_lst,
    input  logic [CNW-1:0]     cfg_dly,
    input  logic               ctl_arm,
    input  logic               ctl_abort,
    output logic               sts_armed,
    output logic [SIW-1:0]     sts_stage,
    output logic [CHN-1:0]     sts_hit,
    output logic               sts_evt,
    trigger_sequencer_if.slave sti
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ARMED = ARMED;
    localparam logic [1:0] ST_DELAY = DELAY;

    logic [1:0]     state;
    logic [SDW-1:0] prv;
    logic [CNW-1:0] occ;
    logic [CNW-1:0] dly;
    logic [CHN-1:0] hit;
    logic [CNW-1:0] cnt_arr [CHN];
    logic [SIW-1:0] lst;
    logic [CNW-1:0] cnt_cur;

    for (genvar c = 0; c < CHN; c++) begin : g_ch
        trigger_match #(.SDW(SDW)) u_match (
            .prv     (prv),
            .data    (sti.sti_tdata),
            .cfg_or  (cfg_or [c*SDW +: SDW]),
            .cfg_and (cfg_and[c*SDW +: SDW]),
            .cfg_0_0 (cfg_0_0[c*SDW +: SDW]),
            .cfg_0_1 (cfg_0_1[c*SDW +: SDW]),
            .cfg_1_0 (cfg_1_0[c*SDW +: SDW]),
            .cfg_1_1 (cfg_1_1[c*SDW +: SDW]),
            .hit     (hit[c])
        );
        assign cnt_arr[c] = cfg_cnt[c*CNW +: CNW];
    end

    assign lst     = SIW'(clamp_stage(int'(cfg_lst), CHN - 1));
    assign cnt_cur = cnt_arr[sts_stage];

    // Comparators evaluate every transfer; only the current stage's hit advances.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            prv       <= '0;
            occ       <= '0;
            dly       <= '0;
            sts_armed <= 1'b0;
            sts_stage <= '0;
            sts_hit   <= '0;
            sts_evt   <= 1'b0;
        end else begin
            sts_evt <= 1'b0;
            if (sti.sti_transfer) begin
                prv     <= sti.sti_tdata;
                sts_hit <= hit;
            end

            if (ctl_abort) begin
                state     <= ST_IDLE;
                sts_armed <= 1'b0;
            end else if (ctl_arm) begin
                state     <= ST_ARMED;
                sts_armed <= 1'b1;
                sts_stage <= '0;
                occ       <= '0;
                dly       <= '0;
            end else if (sti.sti_transfer) begin
                case (state)
                    ST_ARMED: begin
                        if (hit[sts_stage]) begin
                            if (occ == cnt_cur) begin
                                occ <= '0;
                                if (sts_stage < lst) begin
                                    sts_stage <= sts_stage + SIW'(1);
                                end else if (cfg_dly != '0) begin
                                    state <= ST_DELAY;
                                    dly   <= '0;
                                end else begin
                                    state     <= ST_IDLE;
                                    sts_armed <= 1'b0;
                                    sts_evt   <= 1'b1;
                                end
                            end else begin
                                occ <= occ + CNW'(1);
                            end
                        end
                    end
                    ST_DELAY: begin
                        if ((dly + CNW'(1)) == cfg_dly) begin
                            state     <= ST_IDLE;
                            sts_armed <= 1'b0;
                            sts_evt   <= 1'b1;
                        end else begin
                            dly <= dly + CNW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed-vector bench for trigger_sequencer with hand-computed expectations.
module tb_trigger_sequencer;
    localparam int SDW = 32;
    localparam int CHN = 4;
    localparam int CNW = 16;
    localparam int SIW = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [CHN*SDW-1:0] cfg_or, cfg_and, cfg_0_0, cfg_0_1, cfg_1_0, cfg_1_1;
    logic [CHN*CNW-1:0] cfg_cnt;
    logic [SIW-1:0]     cfg_lst;
    logic [CNW-1:0]     cfg_dly;
    logic               ctl_arm = 1'b0;
    logic               ctl_abort = 1'b0;
    logic               sts_armed;
    logic [SIW-1:0]     sts_stage;
    logic [CHN-1:0]     sts_hit;
    logic               sts_evt;

    int n_cmp = 0;
    int n_bad = 0;

    trigger_sequencer_if #(.SDW(SDW)) sti ();

    trigger_sequencer #(.SDW(SDW), .CHN(CHN), .CNW(CNW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_or    (cfg_or),
        .cfg_and   (cfg_and),
        .cfg_0_0   (cfg_0_0),
        .cfg_0_1   (cfg_0_1),
        .cfg_1_0   (cfg_1_0),
        .cfg_1_1   (cfg_1_1),
        .cfg_cnt   (cfg_cnt),
        .cfg_lst   (cfg_lst),
        .cfg_dly   (cfg_dly),
        .ctl_arm   (ctl_arm),
        .ctl_abort (ctl_abort),
        .sts_armed (sts_armed),
        .sts_stage (sts_stage),
        .sts_hit   (sts_hit),
        .sts_evt   (sts_evt),
        .sti       (sti)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic arm, input logic abort, input logic t, input logic [31:0] d);
        @(negedge clk);
        ctl_arm          = arm;
        ctl_abort        = abort;
        sti.sti_transfer = t;
        sti.sti_tdata    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] d);
        step(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic clear_cfg();
        cfg_or = '0; cfg_and = '0; cfg_0_0 = '0; cfg_0_1 = '0;
        cfg_1_0 = '0; cfg_1_1 = '0; cfg_cnt = '0; cfg_lst = '0; cfg_dly = '0;
    endtask

    // Level match on the low byte: bits that must be 1 accept 0->1/1->1, bits that must be 0 accept 0->0/1->0.
    task automatic set_level(input int c, input logic [7:0] v);
        cfg_and[c*SDW +: SDW] = 32'h0000_00FF;
        cfg_0_1[c*SDW +: SDW] = {24'h0, v};
        cfg_1_1[c*SDW +: SDW] = {24'h0, v};
        cfg_0_0[c*SDW +: SDW] = {24'h0, ~v};
        cfg_1_0[c*SDW +: SDW] = {24'h0, ~v};
    endtask

    task automatic three_stage_cfg(input logic [CNW-1:0] d);
        clear_cfg();
        set_level(0, 8'hAA);
        set_level(1, 8'h55);
        set_level(2, 8'hFF);
        cfg_lst = 2'd2;
        cfg_dly = d;
    endtask

    initial begin
        sti.sti_transfer = 1'b0;
        sti.sti_tdata    = '0;
        clear_cfg();

        // Reset state
        rst = 1'b0;
        idle();
        idle();
        chk("rst_evt",   32'(sts_evt),   32'd0);
        chk("rst_armed", 32'(sts_armed), 32'd0);
        chk("rst_stage", 32'(sts_stage), 32'd0);
        chk("rst_hit",   32'(sts_hit),   32'd0);
        rst = 1'b1;

        // Single stage, rising edge on bit 0
        cfg_0_1[0 +: SDW] = 32'h1;
        cfg_or [0 +: SDW] = 32'h1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("s1_armed", 32'(sts_armed), 32'd1);
        xfer(32'h0);
        chk("s1_evt0", 32'(sts_evt), 32'd0);
        xfer(32'h1);
        chk("s1_evt1",   32'(sts_evt),   32'd1);
        chk("s1_hit",    32'(sts_hit),   32'h1);
        chk("s1_disarm", 32'(sts_armed), 32'd0);
        idle();
        chk("s1_pulse", 32'(sts_evt), 32'd0);
        xfer(32'h0);
        xfer(32'h1);
        chk("s1_noretrig", 32'(sts_evt), 32'd0);
        chk("s1_hit2",     32'(sts_hit), 32'h1);

        // Occurrence count: three rising edges required
        cfg_cnt[0 +: CNW] = 16'd2;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            xfer(32'h0);
            xfer(32'h1);
            chk($sformatf("occ_evt%0d", i), 32'(sts_evt), (i == 2) ? 32'd1 : 32'd0);
        end

        // Three stages
        idle();
        three_stage_cfg(16'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("st_stage0", 32'(sts_stage), 32'd0);
        xfer(32'h55);
        chk("st_a_stage", 32'(sts_stage), 32'd0);
        chk("st_a_hit",   32'(sts_hit),   32'h2);
        xfer(32'hAA);
        chk("st_b_stage", 32'(sts_stage), 32'd1);
        chk("st_b_hit",   32'(sts_hit),   32'h1);
        xfer(32'hFF);
        chk("st_c_stage", 32'(sts_stage), 32'd1);
        chk("st_c_evt",   32'(sts_evt),   32'd0);
        xfer(32'h55);
        chk("st_d_stage", 32'(sts_stage), 32'd2);
        xfer(32'hFF);
        chk("st_e_evt", 32'(sts_evt), 32'd1);
        chk("st_e_hit", 32'(sts_hit), 32'h4);

        // Delay of five transfers with gaps
        idle();
        three_stage_cfg(16'd5);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        xfer(32'hAA);
        xfer(32'h55);
        xfer(32'hFF);
        chk("dly_enter_evt",   32'(sts_evt),   32'd0);
        chk("dly_enter_armed", 32'(sts_armed), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            idle();
            chk($sformatf("dly_gap%0d", i), 32'(sts_evt), 32'd0);
            xfer(32'h0);
            chk($sformatf("dly_x%0d", i), 32'(sts_evt), (i == 5) ? 32'd1 : 32'd0);
        end
        idle();
        chk("dly_after", 32'(sts_evt), 32'd0);

        // Abort on the firing transfer
        three_stage_cfg(16'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        xfer(32'hAA);
        xfer(32'h55);
        step(1'b0, 1'b1, 1'b1, 32'hFF);
        chk("abort_evt",   32'(sts_evt),   32'd0);
        chk("abort_armed", 32'(sts_armed), 32'd0);

        // Re-arm mid stage 2 discards the coincident transfer
        step(1'b1, 1'b0, 1'b0, 32'h0);
        xfer(32'hAA);
        xfer(32'h55);
        chk("rearm_pre", 32'(sts_stage), 32'd2);
        step(1'b1, 1'b0, 1'b1, 32'hFF);
        chk("rearm_stage", 32'(sts_stage), 32'd0);
        chk("rearm_evt",   32'(sts_evt),   32'd0);
        chk("rearm_armed", 32'(sts_armed), 32'd1);
        xfer(32'hFF);
        chk("rearm_noevt", 32'(sts_evt), 32'd0);

        // Reset during delay
        three_stage_cfg(16'd5);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        xfer(32'hAA);
        xfer(32'h55);
        xfer(32'hFF);
        xfer(32'h0);
        rst = 1'b0;
        xfer(32'h0);
        rst = 1'b1;
        chk("mrst_evt",   32'(sts_evt),   32'd0);
        chk("mrst_armed", 32'(sts_armed), 32'd0);
        chk("mrst_stage", 32'(sts_stage), 32'd0);
        chk("mrst_hit",   32'(sts_hit),   32'd0);
        begin
            int evts = 0;
            for (int i = 0; i < 6; i++) begin
                xfer(32'h0);
                evts += int'(sts_evt);
            end
            chk("mrst_noevt", 32'(evts), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
